// File: rtl/rle_decompressor_pkg.sv
// -----------------------------------------------------------------------------
// rle_pkg
// Shared types for the run-length codec blocks.
//   byte_t          : one data byte of the plain stream
//   count_t         : run length carried alongside a byte (0 = empty pair)
//   rle_pair_t      : {value, count} pair as buffered by the decompressor
//   rle_dec_state_e : expander FSM states
// -----------------------------------------------------------------------------
package rle_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 8;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    byte_t  value;
    count_t count;
  } rle_pair_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rle_dec_state_e;

  // A zero count carries no bytes; such pairs are dropped silently.
  function automatic logic pair_is_empty(input count_t count);
    return (count == 8'd0);
  endfunction

endpackage : rle_pkg

// File: rtl/rle_decompressor_if.sv
// -----------------------------------------------------------------------------
// rle_decompressor_if
// Bundles the pair input side and the byte output side of the decompressor.
//   data_in/count_in/valid_in : pair offered by the upstream compressor
//   in_ready                  : pair buffer can take a pair this cycle
//   data_out/valid_out        : expanded byte stream
//   out_ready                 : downstream accepts data_out this cycle
//   overflow                  : sticky, a non-empty pair was dropped
// Modports: slave = decompressor, master = environment driving it.
// -----------------------------------------------------------------------------
interface rle_decompressor_if;
  import rle_pkg::*;

  byte_t  data_in;
  count_t count_in;
  logic   valid_in;
  logic   in_ready;
  byte_t  data_out;
  logic   valid_out;
  logic   out_ready;
  logic   overflow;

  modport slave (
    input  data_in,
    input  count_in,
    input  valid_in,
    output in_ready,
    output data_out,
    output valid_out,
    input  out_ready,
    output overflow
  );

  modport master (
    output data_in,
    output count_in,
    output valid_in,
    input  in_ready,
    input  data_out,
    input  valid_out,
    output out_ready,
    input  overflow
  );

endinterface : rle_decompressor_if

// File: rtl/rle_decompressor_pair_fifo.sv
// -----------------------------------------------------------------------------
// rle_pair_fifo
// Synchronous FIFO of rle_pair_t with registered full/empty flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata (ignored while full)
//   i_pop      : advance the read pointer (ignored while empty)
//   i_wdata    : pair to write
//   o_rdata    : head pair, valid whenever o_empty = 0
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rle_pair_fifo
  import rle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  rle_pair_t i_wdata,
  output rle_pair_t o_rdata,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  rle_pair_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // A push while full is refused even if a pop happens in the same cycle.
  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  // Next occupancy, used to register full/empty.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule : rle_pair_fifo

// File: rtl/rle_decompressor.sv
// -----------------------------------------------------------------------------
// rle_decompressor
// Expands (byte, count) pairs into a plain byte stream, one byte per cycle.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rle_decompressor_if.slave
//             pair in  : data_in, count_in, valid_in -> in_ready
//             byte out : data_out, valid_out         <- out_ready
//             overflow : sticky drop indicator, cleared only by reset
// Pairs are buffered in rle_pair_fifo; the expander pops the head pair and
// repeats its byte 'count' times, chaining into the next pair without a
// bubble. in_ready and valid_out come straight from registers.
// -----------------------------------------------------------------------------
module rle_decompressor
  import rle_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  rle_decompressor_if.slave bus
);

  rle_pair_t      w_wdata;
  rle_pair_t      w_rdata;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_offer;

  rle_dec_state_e r_state;
  byte_t          r_data_out;
  count_t         r_remaining;
  logic           r_valid_out;
  logic           r_overflow;

  // Empty pairs are neither stored nor counted as overflow.
  assign w_offer       = bus.valid_in && !pair_is_empty(bus.count_in);
  assign w_push        = w_offer && !w_full;
  assign w_wdata.value = bus.data_in;
  assign w_wdata.count = bus.count_in;

  // Pop when idle with data waiting, or when the last byte of the current
  // run is being accepted and another pair is already buffered.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_pop = 1'b0;
        end
      end
      EMIT: begin
        if (bus.out_ready && (r_remaining <= 8'd1) && !w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_pop = 1'b0;
        end
      end
      default: w_pop = 1'b0;
    endcase
  end

  rle_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Expander FSM: loads pairs from the FIFO head and counts down each run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data_out  <= 8'd0;
      r_remaining <= 8'd0;
      r_valid_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_data_out  <= w_rdata.value;
            r_remaining <= w_rdata.count;
            r_valid_out <= 1'b1;
            r_state     <= EMIT;
          end else begin
            r_valid_out <= 1'b0;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (r_remaining > 8'd1) begin
              r_remaining <= r_remaining - 8'd1;
            end else if (!w_empty) begin
              r_data_out  <= w_rdata.value;
              r_remaining <= w_rdata.count;
            end else begin
              r_remaining <= 8'd0;
              r_valid_out <= 1'b0;
              r_state     <= IDLE;
            end
          end else begin
            r_valid_out <= 1'b1;
          end
        end
        default: begin
          r_valid_out <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a non-empty pair arrived while the buffer was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_offer && w_full) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.overflow  = r_overflow;

endmodule : rle_decompressor

// File: tb/tb_rle_decompressor.sv
// -----------------------------------------------------------------------------
// tb_rle_decompressor
// Directed bench for rle_decompressor. Inputs change 1 ns after a rising
// edge; outputs are observed on the falling edge, where handshakes about to
// complete are logged into rx together with their cycle number.
// -----------------------------------------------------------------------------
module tb_rle_decompressor;
  import rle_pkg::*;

  logic clk;
  logic rst_n;

  rle_decompressor_if bus_if ();

  rle_decompressor #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_n    = 0;
  byte_t rx[$];
  int    hs_cyc[$];
  logic  prev_stall = 1'b0;
  byte_t prev_data  = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return 1 ns after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", 32'(bus_if.valid_out), 32'd1);
      chk("hold_data", 32'(bus_if.data_out), 32'(prev_data));
    end
    prev_stall = bus_if.valid_out && !bus_if.out_ready;
    prev_data  = bus_if.data_out;
    if (bus_if.valid_out && bus_if.out_ready) begin
      rx.push_back(bus_if.data_out);
      hs_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_rx();
    rx.delete();
    hs_cyc.delete();
  endtask

  task automatic push(input byte_t v, input count_t c);
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = v;
    bus_if.count_in = c;
    cyc();
    bus_if.valid_in = 1'b0;
  endtask

  task automatic run_until(input string tag, input int n, input bit toggle, input int bound);
    for (int i = 0; i < bound && rx.size() < n; i++) begin
      if (toggle) bus_if.out_ready = !bus_if.out_ready;
      cyc();
    end
    chk(tag, 32'(rx.size()), 32'(n));
  endtask

  task automatic check_rx(input string tag, input byte_t exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      chk(tag, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp[i]));
    end
  endtask

  initial begin
    byte_t seq1[$];
    byte_t seq4[$];
    seq1 = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43};
    seq4 = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h14, 8'h14};

    rst_n            = 1'b0;
    bus_if.data_in   = 8'd0;
    bus_if.count_in  = 8'd0;
    bus_if.valid_in  = 1'b0;
    bus_if.out_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
    chk("rst_data_out", 32'(bus_if.data_out), 32'd0);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("rst_overflow", 32'(bus_if.overflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back pairs, out_ready held high; also first-byte latency
    clear_rx();
    push(8'h41, 8'd4);
    chk("lat_edge_n", 32'(bus_if.valid_out), 32'd0);
    push(8'h42, 8'd2);
    chk("lat_edge_n1_valid", 32'(bus_if.valid_out), 32'd1);
    chk("lat_edge_n1_data", 32'(bus_if.data_out), 32'h41);
    push(8'h43, 8'd1);
    run_until("t1_count", 7, 1'b0, 40);
    check_rx("t1_byte", seq1);
    chk("t1_consecutive", 32'(hs_cyc[6] - hs_cyc[0]), 32'd6);
    chk("t1_valid_drop", 32'(bus_if.valid_out), 32'd0);

    // Same pairs with out_ready toggling every cycle
    clear_rx();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.out_ready = !bus_if.out_ready;
      push(seq1[(i == 0) ? 0 : ((i == 1) ? 4 : 6)], count_t'((i == 0) ? 4 : ((i == 1) ? 2 : 1)));
    end
    run_until("t2_count", 7, 1'b1, 60);
    check_rx("t2_byte", seq1);
    chk("t2_valid_drop", 32'(bus_if.valid_out), 32'd0);

    // Empty pair is discarded without overflow
    clear_rx();
    bus_if.out_ready = 1'b1;
    prev_stall       = 1'b0;
    push(8'h55, 8'd0);
    push(8'h66, 8'd1);
    run_until("t3_count", 1, 1'b0, 20);
    check_rx("t3_byte", '{8'h66});
    chk("t3_valid_drop", 32'(bus_if.valid_out), 32'd0);
    chk("t3_overflow", 32'(bus_if.overflow), 32'd0);
    chk("t3_in_ready", 32'(bus_if.in_ready), 32'd1);

    // Backpressure: expander holds one pair, FIFO holds four, sixth is dropped
    clear_rx();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(byte_t'(8'h10 + i), 8'd2);
      if (i == 3) chk("t4_ready_after_4", 32'(bus_if.in_ready), 32'd1);
    end
    chk("t4_ready_after_5", 32'(bus_if.in_ready), 32'd0);
    chk("t4_no_overflow_yet", 32'(bus_if.overflow), 32'd0);
    push(8'h15, 8'd2);
    chk("t4_overflow", 32'(bus_if.overflow), 32'd1);
    chk("t4_ready_still_low", 32'(bus_if.in_ready), 32'd0);
    chk("t4_hold_first", 32'(bus_if.data_out), 32'h10);
    bus_if.out_ready = 1'b1;
    run_until("t4_count", 10, 1'b0, 40);
    check_rx("t4_byte", seq4);
    chk("t4_valid_drop", 32'(bus_if.valid_out), 32'd0);
    chk("t4_overflow_sticky", 32'(bus_if.overflow), 32'd1);
    chk("t4_ready_back", 32'(bus_if.in_ready), 32'd1);

    // Maximum run length
    clear_rx();
    push(8'h7F, 8'd255);
    run_until("t5_count", 255, 1'b0, 300);
    for (int i = 0; i < 255; i++) begin
      chk("t5_byte", (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'h7F);
    end
    chk("t5_consecutive", 32'(hs_cyc[254] - hs_cyc[0]), 32'd254);
    chk("t5_valid_drop", 32'(bus_if.valid_out), 32'd0);

    // Reset in the middle of a run
    clear_rx();
    push(8'h41, 8'd4);
    run_until("t6_pre_count", 2, 1'b0, 20);
    chk("t6_valid_before", 32'(bus_if.valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus_if.valid_out), 32'd0);
    chk("t6_rst_data", 32'(bus_if.data_out), 32'd0);
    chk("t6_rst_overflow", 32'(bus_if.overflow), 32'd0);
    chk("t6_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    clear_rx();
    for (int i = 0; i < 10; i++) cyc();
    chk("t6_no_stale", 32'(rx.size()), 32'd0);
    chk("t6_idle_valid", 32'(bus_if.valid_out), 32'd0);
    push(8'h41, 8'd1);
    run_until("t6_new_count", 1, 1'b0, 20);
    check_rx("t6_new_byte", '{8'h41});
    chk("t6_valid_drop", 32'(bus_if.valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rle_decompressor
